// File: rtl/df_coeff_bank.sv
// Double-buffered coefficient bank for the direct-form I stage: writes land in a shadow
// bank and move to the active bank on a sample strobe. Optional readback: DF_COEFF_READBACK_EN.

module df_coeff_slot #(
  parameter int               W       = 16,
  parameter logic [W-1:0]     RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         swap,
  output logic [W-1:0] shadow,
  output logic [W-1:0] active
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= RST_VAL;
      active <= RST_VAL;
    end else begin
      if (load) shadow <= data;
      if (swap) active <= shadow;
    end
  end
endmodule

module df_coeff_bank #(
  parameter int N           = 3,
  parameter int COEFF_WIDTH = 16,
  parameter int Q           = 14,
  parameter int ADDR_WIDTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [COEFF_WIDTH-1:0]       wr_data,
  output logic                         wr_ready,
  input  logic                         commit,
  input  logic                         abort,
  input  logic                         sample_strobe,
  output logic [COEFF_WIDTH*(N+1)-1:0] packed_coeffs,
  output logic                         pending,
  output logic                         commit_done,
  output logic                         addr_err,
  output logic [7:0]                   commit_count
`ifdef DF_COEFF_READBACK_EN
  ,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic [COEFF_WIDTH-1:0]       rd_data
`endif
);
  localparam logic [COEFF_WIDTH-1:0] UNITY = COEFF_WIDTH'(1) << Q;

  typedef enum logic [1:0] {IDLE, LOADING, PENDING} state_t;

  state_t state, state_next;
  logic   wr_try, addr_ok, wr_hit, err_set, swap;
  logic [N:0][COEFF_WIDTH-1:0] shadow, active;

  assign addr_ok = (32'(wr_addr) <= 32'(N));
  assign wr_try  = wr_en && wr_ready;
  assign wr_hit  = wr_try && addr_ok;
  assign err_set = wr_try && !addr_ok;

  always_comb begin
    state_next = state;
    swap       = 1'b0;
    case (state)
      IDLE: begin
        if (commit)      state_next = PENDING;
        else if (wr_hit) state_next = LOADING;
      end
      LOADING: begin
        if (commit) state_next = PENDING;
      end
      PENDING: begin
        // A strobe coinciding with abort still swaps.
        if (sample_strobe) begin
          swap       = 1'b1;
          state_next = IDLE;
        end else if (abort) begin
          state_next = LOADING;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ready     <= 1'b1;
      commit_done  <= 1'b0;
      addr_err     <= 1'b0;
      commit_count <= 8'd0;
    end else begin
      state       <= state_next;
      // Tracks state_next so wr_ready is a flop yet always equals (state != PENDING).
      wr_ready    <= (state_next != PENDING);
      commit_done <= swap;
      if (swap) begin
        commit_count <= commit_count + 8'd1;
        addr_err     <= 1'b0;
      end else if (err_set) begin
        addr_err <= 1'b1;
      end
    end
  end

  for (genvar t = 0; t <= N; t++) begin : g_slot
    localparam logic [COEFF_WIDTH-1:0] RV = (t == 0) ? UNITY : '0;
    df_coeff_slot #(.W(COEFF_WIDTH), .RST_VAL(RV)) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (wr_hit && (wr_addr == ADDR_WIDTH'(t))),
      .data   (wr_data),
      .swap   (swap),
      .shadow (shadow[t]),
      .active (active[t])
    );
  end

  assign packed_coeffs = active;
  assign pending       = (state == PENDING);

`ifdef DF_COEFF_READBACK_EN
  logic [COEFF_WIDTH-1:0] rd_next;

  always_comb begin
    rd_next = '0;
    for (int t = 0; t <= N; t++)
      if (rd_addr == ADDR_WIDTH'(t)) rd_next = shadow[t];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= rd_next;
  end
`endif
endmodule

// File: tb/tb_df_coeff_bank.sv
// Self-checking bench for df_coeff_bank: directed vector table, corner sequences and
// randomized traffic against a bank-level reference model.

module tb_df_coeff_bank;
  localparam int N = 3, W = 16, Q = 14, AW = 3;
  localparam logic [63:0] RST_C = 64'h0000_0000_0000_4000;
  localparam logic [63:0] NEW_C = 64'h0400_3000_2000_1000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic wr_en = 1'b0, commit = 1'b0, abort = 1'b0, sample_strobe = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          wr_ready, pending, commit_done, addr_err;
  logic [W*(N+1)-1:0] packed_coeffs;
  logic [7:0]    commit_count;

  int compared = 0, mismatched = 0, done_seen = 0;

  df_coeff_bank #(.N(N), .COEFF_WIDTH(W), .Q(Q), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .commit(commit), .abort(abort), .sample_strobe(sample_strobe),
    .packed_coeffs(packed_coeffs), .pending(pending), .commit_done(commit_done),
    .addr_err(addr_err), .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  // Reference model: shadow/active arrays plus "commit waiting" flag.
  logic [W-1:0] sh_m [4];
  logic [W-1:0] ac_m [4];
  bit   pend_m, done_m, err_m;
  logic [7:0] cnt_m;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin sh_m[i] = '0; ac_m[i] = '0; end
    sh_m[0] = 16'h4000; ac_m[0] = 16'h4000;
    pend_m = 0; done_m = 0; err_m = 0; cnt_m = 8'd0;
  endfunction

  function automatic logic [63:0] model_coeffs();
    return {ac_m[3], ac_m[2], ac_m[1], ac_m[0]};
  endfunction

  function automatic void model_step(bit we, logic [AW-1:0] a, logic [W-1:0] d, bit c, bit ab, bit s);
    done_m = 0;
    if (pend_m) begin
      if (s) begin
        for (int i = 0; i < 4; i++) ac_m[i] = sh_m[i];
        done_m = 1; cnt_m = cnt_m + 8'd1; err_m = 0; pend_m = 0;
      end else if (ab) pend_m = 0;
    end else begin
      if (we) begin
        if (a <= 3) sh_m[a[1:0]] = d;
        else        err_m = 1;
      end
      if (c) pend_m = 1;
    end
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(bit we, logic [AW-1:0] a, logic [W-1:0] d, bit c, bit ab, bit s);
    wr_en = we; wr_addr = a; wr_data = d; commit = c; abort = ab; sample_strobe = s;
    @(posedge clk);
    model_step(we, a, d, c, ab, s);
    #1;
    if (commit_done === 1'b1) done_seen++;
    chk("coeffs",   64'(packed_coeffs), model_coeffs());
    chk("pending",  64'(pending),       64'(pend_m));
    chk("wr_ready", 64'(wr_ready),      64'(!pend_m));
    chk("done",     64'(commit_done),   64'(done_m));
    chk("addr_err", 64'(addr_err),      64'(err_m));
    chk("count",    64'(commit_count),  64'(cnt_m));
    wr_en = 0; commit = 0; abort = 0; sample_strobe = 0;
  endtask

  typedef struct {
    bit we; logic [AW-1:0] a; logic [W-1:0] d; bit c; bit ab; bit s;
    bit e_pend; bit e_ready; bit e_done; logic [63:0] e_coeffs; logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{1, 3'd0, 16'h1000, 0, 0, 0, 0, 1, 0, RST_C, 8'd0};
    vecs[1]  = '{1, 3'd1, 16'h2000, 0, 0, 0, 0, 1, 0, RST_C, 8'd0};
    vecs[2]  = '{1, 3'd2, 16'h3000, 0, 0, 0, 0, 1, 0, RST_C, 8'd0};
    vecs[3]  = '{1, 3'd3, 16'h0400, 0, 0, 0, 0, 1, 0, RST_C, 8'd0};
    vecs[4]  = '{0, 3'd0, 16'h0000, 1, 0, 0, 1, 0, 0, RST_C, 8'd0};
    for (int i = 5; i < 9; i++)
      vecs[i] = '{0, 3'd0, 16'h0000, 0, 0, 0, 1, 0, 0, RST_C, 8'd0};
    vecs[9]  = '{0, 3'd0, 16'h0000, 0, 0, 1, 0, 1, 1, NEW_C, 8'd1};
    vecs[10] = '{0, 3'd0, 16'h0000, 0, 0, 0, 0, 1, 0, NEW_C, 8'd1};

    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_coeffs", 64'(packed_coeffs), RST_C);
    chk("rst_ready",  64'(wr_ready), 64'd1);
    chk("rst_pend",   64'(pending), 64'd0);
    chk("rst_count",  64'(commit_count), 64'd0);

    // Load four coefficients, commit, strobe five cycles later.
    foreach (vecs[i]) begin
      step(vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].c, vecs[i].ab, vecs[i].s);
      chk("vec_pend",   64'(pending), 64'(vecs[i].e_pend));
      chk("vec_ready",  64'(wr_ready), 64'(vecs[i].e_ready));
      chk("vec_done",   64'(commit_done), 64'(vecs[i].e_done));
      chk("vec_coeffs", 64'(packed_coeffs), vecs[i].e_coeffs);
      chk("vec_count",  64'(commit_count), 64'(vecs[i].e_cnt));
    end

    // Writes and re-commit while pending are ignored.
    done_seen = 0;
    step(0, 0, 0, 1, 0, 0);
    step(1, 3'd1, 16'h7FFF, 1, 0, 0);
    chk("pend_ready", 64'(wr_ready), 64'd0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("pend_h1", 64'(packed_coeffs[31:16]), 64'h2000);
    chk("pend_dones", 64'(done_seen), 64'd1);

    // Abort leaves the edit loaded but unapplied.
    step(1, 3'd2, 16'hFFFF, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("abort_pend", 64'(pending), 64'd0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("abort_coeffs", 64'(packed_coeffs), NEW_C);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("abort_h2", 64'(packed_coeffs[47:32]), 64'hFFFF);

    // Top address accepted; out-of-range address flags and is cleared by a swap.
    step(1, 3'd3, 16'h0123, 0, 0, 0);
    step(1, 3'd5, 16'h5555, 0, 0, 0);
    chk("err_set", 64'(addr_err), 64'd1);
    chk("err_coeffs", 64'(packed_coeffs), 64'h0400_FFFF_2000_1000);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("err_clr", 64'(addr_err), 64'd0);
    chk("err_h3", 64'(packed_coeffs[63:48]), 64'h0123);

    // Commit coinciding with strobe defers the swap to the next strobe.
    step(1, 3'd0, 16'h0055, 1, 0, 1);
    chk("cs_pend", 64'(pending), 64'd1);
    chk("cs_done", 64'(commit_done), 64'd0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("cs_swap", 64'(commit_done), 64'd1);
    chk("cs_h0", 64'(packed_coeffs[15:0]), 64'h0055);

    // Reset while pending discards everything.
    step(1, 3'd0, 16'h7777, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rstp_coeffs", 64'(packed_coeffs), RST_C);
    chk("rstp_pend", 64'(pending), 64'd0);
    chk("rstp_ready", 64'(wr_ready), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("rstp_shadow", 64'(packed_coeffs), RST_C);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 2) == 0, AW'($urandom_range(0, 5)), W'($urandom),
           $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
